// File: rtl/frequency_result_sequencer_if.sv
// Register-file access bus between the result sequencer (master) and the register file (slave).
interface frequency_result_sequencer_if;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic [31:0] register_read;

    modport master (
        output register_operation,
        output register_number,
        output register_write,
        input  register_read
    );

    modport slave (
        input  register_operation,
        input  register_number,
        input  register_write,
        output register_read
    );
endinterface

// File: rtl/frequency_result_sequencer.sv
// Reads the light threshold, then publishes a snapshot of analyzer results to the register file.
// Optional threshold readback state is enabled by FREQUENCY_SEQUENCER_CONFIG_READBACK_EN.
module frequency_result_sequencer #(
    parameter int unsigned RESULTS_NUMBER          = 9,
    parameter int unsigned HOLD_CYCLES             = 4,
    parameter int unsigned THRESHOLD_REGISTER      = 10,
    parameter int unsigned DEFAULT_THRESHOLD_VALUE = 96
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    input  logic [RESULTS_NUMBER*32-1:0] result_data,
    frequency_result_sequencer_if.master reg_bus,
    output logic [7:0]                   light_threshold,
    output logic                         config_done,
    output logic                         analyzer_clear,
    output logic                         busy,
    output logic                         irq
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam int unsigned IdxW  = $clog2(RESULTS_NUMBER + 1);
    localparam int unsigned SelW  = (RESULTS_NUMBER > 1) ? $clog2(RESULTS_NUMBER) : 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(RESULTS_NUMBER);

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StRun,
        StWrite,
        StDone
    } state_e;

    state_e           r_state, w_state_next;
    logic [HoldW-1:0] r_hold, w_hold_next;
    logic [IdxW-1:0]  r_index, w_index_next;
    logic [7:0]       r_threshold, w_threshold_next;
    logic             r_config_done, w_config_done_next;
    logic             r_clear_pulse, w_clear_pulse_next;
    logic             r_start_q, r_stop_q;
    logic             w_start_edge, w_stop_edge;
    logic             w_snap_load, w_snap_clear;
    logic [SelW-1:0]  w_word_sel;
    logic [31:0]      r_snap [RESULTS_NUMBER];

    assign w_start_edge = start & ~r_start_q;
    assign w_stop_edge  = stop & ~r_stop_q;
    assign w_word_sel   = SelW'(r_index - IdxW'(1));

`ifndef FREQUENCY_SEQUENCER_CONFIG_READBACK_EN
    logic       w_unused_read;
    logic [7:0] w_unused_cfg_num;
    assign w_unused_read    = ^reg_bus.register_read;
    assign w_unused_cfg_num = 8'(THRESHOLD_REGISTER);
`endif

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state       <= StIdle;
            r_hold        <= '0;
            r_index       <= '0;
            r_threshold   <= 8'(DEFAULT_THRESHOLD_VALUE);
            r_config_done <= 1'b0;
            r_clear_pulse <= 1'b0;
            r_start_q     <= 1'b0;
            r_stop_q      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold        <= w_hold_next;
            r_index       <= w_index_next;
            r_threshold   <= w_threshold_next;
            r_config_done <= w_config_done_next;
            r_clear_pulse <= w_clear_pulse_next;
            r_start_q     <= start;
            r_stop_q      <= stop;
        end
    end

    // Snapshot isolates the write phase from live analyzer updates.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int k = 0; k < RESULTS_NUMBER; k++) r_snap[k] <= '0;
        end else if (w_snap_clear) begin
            for (int k = 0; k < RESULTS_NUMBER; k++) r_snap[k] <= '0;
        end else if (w_snap_load) begin
            for (int k = 0; k < RESULTS_NUMBER; k++) r_snap[k] <= result_data[32*k +: 32];
        end
    end

    always_comb begin
        w_state_next                = r_state;
        w_hold_next                 = r_hold;
        w_index_next                = r_index;
        w_threshold_next            = r_threshold;
        w_config_done_next          = r_config_done;
        w_clear_pulse_next          = 1'b0;
        w_snap_load                 = 1'b0;
        w_snap_clear                = 1'b0;
        reg_bus.register_operation  = 2'd0;
        reg_bus.register_number     = 8'd0;
        reg_bus.register_write      = 32'd0;
        busy                        = 1'b0;
        irq                         = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_start_edge) begin
`ifdef FREQUENCY_SEQUENCER_CONFIG_READBACK_EN
                    w_state_next = StCfg;
                    w_hold_next  = '0;
`else
                    w_state_next       = StRun;
                    w_config_done_next = 1'b1;
`endif
                end
            end
`ifdef FREQUENCY_SEQUENCER_CONFIG_READBACK_EN
            StCfg: begin
                reg_bus.register_operation = 2'd1;
                reg_bus.register_number    = 8'(THRESHOLD_REGISTER);
                busy                       = 1'b1;
                if (r_hold == HoldLast) begin
                    // A zero readback means the register was never programmed.
                    if (reg_bus.register_read != 32'd0) begin
                        w_threshold_next = reg_bus.register_read[7:0];
                    end
                    w_config_done_next = 1'b1;
                    w_hold_next        = '0;
                    w_state_next       = StRun;
                end else begin
                    w_hold_next = r_hold + HoldW'(1);
                end
            end
`endif
            StRun: begin
                if (w_stop_edge) begin
                    w_snap_load  = 1'b1;
                    w_index_next = IdxW'(1);
                    w_hold_next  = '0;
                    w_state_next = StWrite;
                end
            end
            StWrite: begin
                reg_bus.register_operation = 2'd2;
                reg_bus.register_number    = 8'(r_index);
                reg_bus.register_write     = r_snap[w_word_sel];
                busy                       = 1'b1;
                if (r_hold == HoldLast) begin
                    w_hold_next = '0;
                    if (r_index == IdxLast) begin
                        w_index_next       = '0;
                        w_clear_pulse_next = 1'b1;
                        w_state_next       = StDone;
                    end else begin
                        w_index_next = r_index + IdxW'(1);
                    end
                end else begin
                    w_hold_next = r_hold + HoldW'(1);
                end
            end
            StDone: begin
                irq = 1'b1;
                if (!stop) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase

        if (clear) begin
            w_state_next       = StIdle;
            w_hold_next        = '0;
            w_index_next       = '0;
            w_snap_clear       = 1'b1;
            w_clear_pulse_next = 1'b0;
        end
    end

    assign light_threshold = r_threshold;
    assign config_done     = r_config_done;
    assign analyzer_clear  = r_clear_pulse;

endmodule

// File: doc/frequency_result_sequencer.md
FREQUENCY_RESULT_SEQUENCER -- requirements
Module: frequency_result_sequencer

Interface
REQ-001 SHALL have parameter RESULTS_NUMBER, default 9: number of 32-bit result words published per measurement.
REQ-002 SHALL have parameter HOLD_CYCLES, default 4 (range 2..15): cycles each register access is held stable.
REQ-003 SHALL have parameter THRESHOLD_REGISTER, default 10: register number read for the light threshold.
REQ-004 SHALL have parameter DEFAULT_THRESHOLD_VALUE, default 96: threshold used when no valid readback occurs.
REQ-005 SHALL have port s00_axi_aclk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port s00_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports start, stop, clear, input, 1 each: level controls, synchronous to s00_axi_aclk.
REQ-008 SHALL have port result_data, input, RESULTS_NUMBER*32: analyzer results; word k is bits [32k+31:32k].
REQ-009 SHALL have port register_read, input, 32: register-file read data.
REQ-010 SHALL have ports register_operation (output, 2: 0 none, 1 read, 2 write), register_number (output, 8) and register_write (output, 32).
REQ-011 SHALL have ports light_threshold (output, 8), config_done (output, 1), analyzer_clear (output, 1), busy (output, 1) and irq (output, 1).

Function
REQ-012 SHALL implement states IDLE, CFG, RUN, WRITE, DONE.
REQ-013 IDLE: outputs idle. A start rising edge (start=1, previous sample 0) SHALL go to CFG.
REQ-014 CFG: drive op=1 and number=THRESHOLD_REGISTER for HOLD_CYCLES cycles, then sample register_read on the last cycle.
REQ-015 CFG exit: nonzero sample loads light_threshold=register_read[7:0]; zero keeps the current value. Then set config_done=1 and go to RUN.
REQ-016 RUN: op=0. A stop rising edge SHALL snapshot all of result_data into an internal buffer in that same cycle, set index=1 and go to WRITE.
REQ-017 WRITE: drive op=2, number=index and write=snapshot word index-1, all stable for HOLD_CYCLES cycles.
REQ-018 WRITE advance: after the hold, index increments. After index=RESULTS_NUMBER completes, go to DONE, so the phase lasts exactly RESULTS_NUMBER*HOLD_CYCLES cycles.
REQ-019 result_data changes during WRITE SHALL NOT affect the written values.
REQ-020 DONE: op=0, number=0, write=0 and irq=1. analyzer_clear SHALL pulse high for exactly 1 cycle on DONE entry.
REQ-021 DONE exit: remain in DONE while stop=1; stop=0 returns to IDLE and clears irq.
REQ-022 busy SHALL be 1 in CFG and WRITE, and 0 otherwise.
REQ-023 clear=1 in any state SHALL go to IDLE next cycle: op=0, irq=0, snapshot discarded; light_threshold and config_done retained.
REQ-024 Simultaneous start and stop rising edges in IDLE: start wins; the stop edge is ignored.
REQ-025 A stop edge during CFG is ignored. Start edges outside IDLE are ignored.
REQ-026 The hold counter and index SHALL be sized for HOLD_CYCLES and RESULTS_NUMBER; index never wraps past RESULTS_NUMBER.

Reset
REQ-027 On s00_axi_aresetn=0, asynchronously set: state IDLE, all counters 0, register_operation=0, register_number=0, register_write=0, light_threshold=DEFAULT_THRESHOLD_VALUE, config_done=0, analyzer_clear=0, busy=0, irq=0, edge detectors 0.
REQ-028 Reset asserted mid-WRITE aborts immediately; no partial index is resumed after release.

Configuration
REQ-029 Macro FREQUENCY_SEQUENCER_CONFIG_READBACK_EN defined: CFG behaves as REQ-014/015.
REQ-030 Macro undefined: CFG is not built. A start edge goes IDLE->RUN directly with config_done=1, and light_threshold stays DEFAULT_THRESHOLD_VALUE; no read is ever issued.

Verification
REQ-031 Reset, then start edge with register_read=0x40 (macro on) -> op=1 and number=10 for 4 cycles, then light_threshold=0x40 and config_done=1.
REQ-032 Same with register_read=0 -> light_threshold stays 96.
REQ-033 In RUN, result words 0..8 = 0x100..0x108, stop edge -> 9 writes, number 1..9, data 0x100..0x108, 4 cycles each, 36 cycles total; then irq=1 and one analyzer_clear pulse.
REQ-034 Change result_data mid-WRITE -> written data still equals the snapshot; stop deassert -> irq=0, state IDLE.
REQ-035 clear at index 5 -> op=0 next cycle, IDLE, threshold retained; assert s00_axi_aresetn=0 mid-WRITE -> all outputs reset asynchronously.
REQ-036 Macro off: start edge -> no op=1 ever, config_done=1 next cycle, light_threshold=96.
